serial_shift_ctrl: RTL and testbench
====================================

Name: serial_shift_ctrl

Overview:
- Controller that sequences an internal N-bit shift register for full-duplex serial transfer, LSB first.
- Accepts a parallel word on a valid/ready handshake, loads it, and shifts it out over N cycles while capturing Ser_in into the MSB.
- Presents the received word and a Done pulse, then enforces a programmable idle gap before the next transfer.
- Sits between the parallel register datapath and a serial link or peripheral.

Parameters:
N, 8, data word width in bits (N >= 2)
GAP, 2, idle cycles inserted after each completed transfer before the next word is accepted (GAP >= 0)
CW, $clog2(N), bit-counter width (derived; do not override)

Ports:
Clk  input  1  system clock; all state changes on posedge Clk
Reset  input  1  synchronous reset, active-high
In_valid  input  1  parallel word offered
In_ready  output  1  controller can accept a word this cycle
In_data  input  N  parallel word to transmit
Abort  input  1  cancel the transfer in progress
Ser_in  input  1  serial receive bit
Ser_out  output  1  serial transmit bit
Ser_en  output  1  Ser_out valid and Ser_in sampled this cycle
Bit_cnt  output  CW  index of the bit currently on Ser_out
Rx_data  output  N  last completed received word
Done  output  1  one-cycle pulse, transfer complete
Aborted  output  1  one-cycle pulse, transfer cancelled
Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; shift register, Bit_cnt, gap counter, Rx_data, Ser_out, Ser_en, Done and Aborted all 0.
- Reset wins over every other input in the same cycle, including mid-shift; no Done or Aborted pulse is produced.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - In_ready=1, Busy=0, Ser_en=0, Ser_out=0.
  - On In_valid at edge t: shreg<=In_data, Bit_cnt<=0, go to SHIFT.
- SHIFT, cycles t+1..t+N:
  - Ser_en=1, Ser_out=shreg[0], In_ready=0.
  - Each edge: shreg<={Ser_in, shreg[N-1:1]} and Bit_cnt++.
  - Edge at the end of cycle t+N (Bit_cnt==N-1): Rx_data<={Ser_in, shreg[N-1:1]}, Done<=1.
  - Next state is GAP if GAP>0, else IDLE.
- Done is high exactly in cycle t+N+1; Rx_data changes only on that edge and holds until the next Done.
- GAP:
  - In_ready=0, Busy=1, Ser_en=0, Ser_out=0.
  - Counts GAP cycles, then IDLE; In_ready returns at cycle t+N+1+GAP.
- Back-to-back: a word held valid during GAP is accepted on the first IDLE cycle. In_valid outside IDLE is ignored, not queued.
- Abort:
  - Only effective in SHIFT.
  - At that edge: state<=IDLE (GAP skipped), Aborted<=1 for one cycle, no Done, Rx_data unchanged, Bit_cnt<=0.
  - Abort in IDLE or GAP is ignored.
  - Abort on the final bit cycle takes priority over completion.
- Bit_cnt reads 0 outside SHIFT.

Test Plan:
- N=8, GAP=2, Ser_out looped to Ser_in, send 8'hA5 accepted at t -> Ser_out over t+1..t+8 = 1,0,1,0,0,1,0,1; Done only at t+9 with Rx_data=8'hA5; In_ready back at t+11.
- Ser_in tied 1, send 8'h00 -> Ser_out all 0 for 8 cycles; Rx_data=8'hFF at Done; Bit_cnt steps 0..7 during SHIFT.
- In_valid held continuously with 8'h3C then 8'hC3 -> second accept exactly at t+11; In_valid during SHIFT/GAP causes no load; both Rx_data values match under loopback.
- Abort asserted during Bit_cnt=3 of 8'hFF -> next cycle IDLE, In_ready=1, Aborted pulses once, no Done, Rx_data keeps its previous value.
- Reset asserted during Bit_cnt=5 -> next cycle all outputs 0, state IDLE, no Done or Aborted; a fresh 8'h5A then transfers correctly.
- GAP=0 build, back-to-back 8'h01, 8'h80 -> In_ready at t+9, second Ser_en window starts t+10; Done pulses at t+9 and t+18.

Source files
------------

// File: rtl/serial_shift_ctrl.sv
// serial_shift_ctrl: full-duplex LSB-first shift controller with
// valid/ready load, abort, Done/Aborted pulses and an idle gap.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   In_valid/In_ready   parallel word handshake, In_data word
//   Abort               cancel a transfer in progress
//   Ser_in/Ser_out      serial receive/transmit bit
//   Ser_en              serial bit valid this cycle
//   Bit_cnt             index of bit currently on Ser_out
//   Rx_data             last completed received word
//   Done/Aborted        one-cycle completion/cancel pulses
//   Busy                controller not idle
module serial_shift_ctrl #(
    parameter int N   = 8,
    parameter int GAP = 2,
    parameter int CW  = $clog2(N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          In_valid,
    output logic          In_ready,
    input  logic [N-1:0]  In_data,
    input  logic          Abort,
    input  logic          Ser_in,
    output logic          Ser_out,
    output logic          Ser_en,
    output logic [CW-1:0] Bit_cnt,
    output logic [N-1:0]  Rx_data,
    output logic          Done,
    output logic          Aborted,
    output logic          Busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Gap counter is kept at least one bit wide so GAP=0/1 builds still
    // elaborate; with GAP=0 the GAP state is simply never entered.
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [N-1:0]  rx_q, rx_d;
    logic          done_q, done_d;
    logic          abt_q, abt_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        rx_d    = rx_q;
        done_d  = 1'b0;
        abt_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (In_valid) begin
                    shreg_d = In_data;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Abort outranks completion, even on the last bit.
                if (Abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    abt_d   = 1'b1;
                end else begin
                    shreg_d = {Ser_in, shreg_q[N-1:1]};
                    if (cnt_q == CW'(N - 1)) begin
                        rx_d    = {Ser_in, shreg_q[N-1:1]};
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        gap_d   = '0;
                        state_d = (GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            rx_q    <= '0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            rx_q    <= rx_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
        end
    end

    assign In_ready = (state_q == S_IDLE);
    assign Busy     = (state_q != S_IDLE);
    assign Ser_en   = (state_q == S_SHIFT);
    assign Ser_out  = Ser_en & shreg_q[0];
    assign Bit_cnt  = cnt_q;
    assign Rx_data  = rx_q;
    assign Done     = done_q;
    assign Aborted  = abt_q;

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// tb_serial_shift_ctrl: directed and randomized transfers against a
// per-cycle expectation derived from word bits and sampled Ser_in.
module tb_serial_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, abort, ser_in, ser_out, ser_en;
    logic [7:0] in_data, rx_data;
    logic [2:0] bit_cnt;
    logic       done, aborted, busy;

    logic       in_valid0, in_ready0, abort0, ser_in0, ser_out0, ser_en0;
    logic [7:0] in_data0, rx_data0;
    logic [2:0] bit_cnt0;
    logic       done0, aborted0, busy0;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_rx;

    always #5 clk = ~clk;

    serial_shift_ctrl #(.N(8), .GAP(2)) dut (
        .Clk(clk), .Reset(rst), .In_valid(in_valid), .In_ready(in_ready),
        .In_data(in_data), .Abort(abort), .Ser_in(ser_in),
        .Ser_out(ser_out), .Ser_en(ser_en), .Bit_cnt(bit_cnt),
        .Rx_data(rx_data), .Done(done), .Aborted(aborted), .Busy(busy)
    );

    serial_shift_ctrl #(.N(8), .GAP(0)) dut0 (
        .Clk(clk), .Reset(rst), .In_valid(in_valid0), .In_ready(in_ready0),
        .In_data(in_data0), .Abort(abort0), .Ser_in(ser_in0),
        .Ser_out(ser_out0), .Ser_en(ser_en0), .Bit_cnt(bit_cnt0),
        .Rx_data(rx_data0), .Done(done0), .Aborted(aborted0), .Busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 loopback, 1 random Ser_in, 2 Ser_in tied 1.
    // stop_at: bit index where Abort (or Reset) hits, -1 for none.
    task automatic xfer(input logic [7:0] w, input int mode,
                        input int stop_at, input bit by_reset,
                        input bit hold, input logic [7:0] next_w);
        logic [7:0] bits;
        bits = '0;
        chk("ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        if (hold) in_data = next_w;
        else in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("ser_en", ser_en, 1);
            chk("ser_out", ser_out, w[k]);
            chk("bit_cnt", bit_cnt, k);
            chk("ready_shift", in_ready, 0);
            chk("done_shift", done, 0);
            case (mode)
                0: ser_in = ser_out;
                1: ser_in = 1'($urandom_range(0, 1));
                default: ser_in = 1'b1;
            endcase
            bits[k] = ser_in;
            if (k == stop_at) begin
                if (by_reset) rst = 1'b1;
                else abort = 1'b1;
            end
            tick();
            abort = 1'b0;
            if (k == stop_at) begin
                in_valid = 1'b0;
                chk("stop_ready", in_ready, 1);
                chk("stop_busy", busy, 0);
                chk("stop_ser_en", ser_en, 0);
                chk("stop_ser_out", ser_out, 0);
                chk("stop_cnt", bit_cnt, 0);
                chk("stop_done", done, 0);
                if (by_reset) begin
                    exp_rx = '0;
                    chk("rst_aborted", aborted, 0);
                    rst = 1'b0;
                end else begin
                    chk("abort_pulse", aborted, 1);
                end
                chk("stop_rx", rx_data, exp_rx);
                tick();
                chk("stop_aborted_clr", aborted, 0);
                chk("stop_no_done", done, 0);
                return;
            end
        end
        exp_rx = bits;
        chk("done_pulse", done, 1);
        chk("rx_data", rx_data, exp_rx);
        chk("ser_en_gap", ser_en, 0);
        chk("ready_gap0", in_ready, 0);
        chk("busy_gap0", busy, 1);
        abort = 1'($urandom_range(0, 1));
        tick();
        chk("done_clr", done, 0);
        chk("ready_gap1", in_ready, 0);
        chk("aborted_gap", aborted, 0);
        abort = 1'($urandom_range(0, 1));
        tick();
        abort = 1'b0;
        chk("aborted_gap2", aborted, 0);
        chk("ready_back", in_ready, 1);
        chk("busy_back", busy, 0);
        chk("rx_hold", rx_data, exp_rx);
    endtask

    // GAP=0 instance, loopback.
    task automatic xfer0(input logic [7:0] w, input bit hold,
                         input logic [7:0] next_w);
        chk("g0_ready", in_ready0, 1);
        in_valid0 = 1'b1;
        in_data0  = w;
        tick();
        if (hold) in_data0 = next_w;
        else in_valid0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("g0_ser_en", ser_en0, 1);
            chk("g0_ser_out", ser_out0, w[k]);
            chk("g0_done_shift", done0, 0);
            ser_in0 = ser_out0;
            tick();
        end
        chk("g0_done", done0, 1);
        chk("g0_rx", rx_data0, w);
        chk("g0_ready_back", in_ready0, 1);
        chk("g0_ser_en_off", ser_en0, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; abort = 1'b0; ser_in = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; abort0 = 1'b0; ser_in0 = 1'b0;
        exp_rx = '0;
        tick();
        tick();
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ser_en", ser_en, 0);
        chk("rst_ser_out", ser_out, 0);
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        rst = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ign", aborted, 0);
        chk("idle_abort_busy", busy, 0);

        xfer(8'hA5, 0, -1, 1'b0, 1'b0, 8'h00);
        xfer(8'h00, 2, -1, 1'b0, 1'b0, 8'h00);
        xfer(8'h3C, 0, -1, 1'b0, 1'b1, 8'hC3);
        xfer(8'hC3, 0, -1, 1'b0, 1'b0, 8'h00);
        xfer(8'hFF, 0, 3, 1'b0, 1'b0, 8'h00);
        xfer(8'h77, 1, 7, 1'b0, 1'b0, 8'h00);
        xfer(8'h96, 1, 5, 1'b1, 1'b0, 8'h00);
        xfer(8'h5A, 0, -1, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 10; i++) begin
            logic [7:0] w;
            int st;
            w  = 8'($urandom);
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            xfer(w, int'($urandom_range(0, 2)), st, 1'b0, 1'b0, 8'h00);
            if ($urandom_range(0, 1) == 1) tick();
        end

        xfer0(8'h01, 1'b1, 8'h80);
        xfer0(8'h80, 1'b0, 8'h00);
        tick();
        chk("g0_done_clr", done0, 0);
        chk("g0_idle", busy0, 0);
        chk("g0_aborted", aborted0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
